// File: rtl/sdc_dma_wbuf.sv
// Posted-write buffer between the SD DMA master port and Avalon-MM memory.
// Writes are queued in a FIFO and acked at once. Reads wait until the FIFO
// has drained, then issue a single memory read.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   s_*                     SD DMA side: request held until the one-cycle s_ack
//   m_*                     Avalon-MM side with waitrequest and pipelined reads
//   fifo_level              number of occupied write entries
//   idle                    FIFO empty, no read in progress, no command out
module sdc_dma_wbuf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_W-1:0]       s_address,
    input  logic [DATA_W-1:0]       s_writedata,
    input  logic [DATA_W/8-1:0]     s_byteenable,
    input  logic                    s_write,
    input  logic                    s_read,
    input  logic                    s_chipselect,
    output logic [DATA_W-1:0]       s_readdata,
    output logic                    s_ack,
    output logic [ADDR_W-1:0]       m_address,
    output logic [DATA_W-1:0]       m_writedata,
    output logic [DATA_W/8-1:0]     m_byteenable,
    output logic                    m_write,
    output logic                    m_read,
    input  logic                    m_waitrequest,
    input  logic [DATA_W-1:0]       m_readdata,
    input  logic                    m_readdatavalid,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    idle
);

    localparam int BE_W = DATA_W / 8;
    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_RD_CMD,
        S_RD_WAIT,
        S_ACK
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [BE_W-1:0]   mem_be_q   [DEPTH];

    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              wr_ack_q, wr_ack_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [BE_W-1:0]   rd_be_q, rd_be_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic req_ok;
    logic wr_req;
    logic rd_req;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic rd_cmd;

    // A request still held during its own ack cycle must not be taken again.
    assign req_ok = s_chipselect & (s_write ^ s_read) & ~s_ack;
    assign wr_req = req_ok & s_write;
    assign rd_req = req_ok & s_read;

    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign rd_cmd = (state_q == S_RD_CMD);

    // Fullness is judged before any same-cycle pop.
    assign push = wr_req & ~full & (state_q == S_IDLE);
    assign pop  = ~empty & ~m_waitrequest;

    // Head entry drives the bus combinationally so the next entry follows
    // a pop without a bubble. A read is only issued with the FIFO empty.
    always_comb begin
        m_write      = ~empty;
        m_read       = rd_cmd;
        m_address    = '0;
        m_writedata  = '0;
        m_byteenable = '0;
        if (!empty) begin
            m_address    = mem_addr_q[rptr_q];
            m_writedata  = mem_data_q[rptr_q];
            m_byteenable = mem_be_q[rptr_q];
        end else if (rd_cmd) begin
            m_address    = rd_addr_q;
            m_byteenable = rd_be_q;
        end
    end

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        wr_ack_d = push;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_be_d   = rd_be_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    state_d   = S_DRAIN;
                    rd_addr_d = s_address;
                    rd_be_d   = s_byteenable;
                end
            end
            S_DRAIN: begin
                if (empty) state_d = S_RD_CMD;
            end
            S_RD_CMD: begin
                if (!m_waitrequest) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (m_readdatavalid) begin
                    state_d = S_ACK;
                    rdata_d = m_readdata;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            wr_ack_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_be_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            wr_ack_q  <= wr_ack_d;
            rd_addr_q <= rd_addr_d;
            rd_be_q   <= rd_be_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr_q[wptr_q] <= s_address;
            mem_data_q[wptr_q] <= s_writedata;
            mem_be_q[wptr_q]   <= s_byteenable;
        end
    end

    assign s_ack      = wr_ack_q | (state_q == S_ACK);
    assign s_readdata = rdata_q;
    assign fifo_level = level_q;
    assign idle       = empty & (state_q == S_IDLE) & ~m_write & ~m_read;

endmodule
